sine_rom_arbiter: RTL and testbench
===================================

// Module: sine_rom_arbiter
// PURPOSE
//   Shares one synchronous-read sine ROM port among N_REQ requesters, e.g. several phase
//   counters or channel generators. Uses a round-robin grant with a req/gnt handshake.
//   Tags each issued read and returns the ROM word to the winning requester two cycles later.
//   Sits between the counter/phase logic and the rom instance, in place of a direct addr hookup.
// PARAMETERS
//   A_WIDTH  8  ROM address width
//   D_WIDTH  8  ROM data width
//   N_REQ    2  number of requesters; legal range 2..4
// PORTS
//   clk        in   1              clock; all state updates on posedge
//   rst        in   1              synchronous reset, active-low (0 = reset)
//   req        in   N_REQ          read request, one bit per requester
//   addr       in   N_REQ*A_WIDTH  request addresses; requester i uses bits [i*A_WIDTH +: A_WIDTH]
//   gnt        out  N_REQ          one-hot grant, combinational, same cycle as req
//   rom_addr   out  A_WIDTH        address to the ROM; the ROM registers it on posedge
//   rom_dout   in   D_WIDTH        ROM read data, valid one cycle after its address is sampled
//   rsp_valid  out  N_REQ          one-hot response strobe, registered
//   rsp_data   out  D_WIDTH        response word, registered; qualified by rsp_valid
// BEHAVIOUR
//   Reset (rst==0 at posedge):
//     - ptr=0, tag pipeline cleared, rsp_valid=0, rsp_data=0, rom_addr register=0.
//     - While rst==0, gnt is forced to 0.
//   Handshake:
//     - A requester holds req and addr stable until it sees gnt.
//     - A transfer occurs in a cycle where req[i]&gnt[i]==1.
//     - At most one transfer per cycle. A requester may re-request in the next cycle.
//   Arbitration:
//     - Scan from index ptr upward, wrapping mod N_REQ. The first set req bit wins.
//     - On a transfer to requester i, ptr <= (i+1) mod N_REQ. With no transfer, ptr holds.
//     - If no req bit is set, gnt=0.
//   Issue path:
//     - rom_addr = addr of the winner, combinational, in the transfer cycle t.
//     - With no transfer, rom_addr = the last issued address. This is a registered copy, so the
//       ROM input does not toggle when idle.
//   Tag pipeline:
//     - Cycle t+1: tag_v<=1 and tag_id<=i, registered from cycle t.
//     - Cycle t+2: rsp_valid[i]<=1 and rsp_data<=rom_dout, registered.
//     - Latency from transfer edge to rsp_valid is 2 cycles.
//     - Throughput is 1 read per cycle, fully pipelined.
//   rsp_valid:
//     - High for exactly one cycle per transfer, then 0.
//     - rsp_data holds its value until the next response.
//   Boundary conditions:
//     - Single requester active: granted every cycle, ptr rotates past it.
//     - All requesters active: strict rotation 0,1,..,N_REQ-1,0.
//     - Reset mid-operation: in-flight tags are dropped. No rsp_valid is produced for them.
//     - A req that drops before its grant is simply not served; no response is generated.
// CONFIGURATION
//   ARB_LOCK_EN
//     - Defined: adds input port lock [N_REQ] after addr.
//       - If the last winner w still has req[w]&lock[w], w is granted again and ptr does not
//         advance.
//       - A 4-bit lock counter limits this to 8 consecutive locked grants. After that,
//         arbitration is forced to resume at (w+1) mod N_REQ for one cycle.
//       - The counter clears when lock[w] or req[w] drops, or on reset.
//     - Undefined: no lock port; plain round-robin as above.
// TESTING
//   1. Reset: hold rst=0 for 3 cycles with all req=1 -> gnt=0, rsp_valid=0, rsp_data=0, rom_addr=0.
//   2. Single read: req=01, addr0=8'h40 at t -> gnt=01 and rom_addr=8'h40 at t; ROM returns
//      8'hFF at t+1 -> rsp_valid=01 and rsp_data=8'hFF at t+2, rsp_valid=00 at t+3.
//   3. Contention: req=11 held for 4 cycles, addr0=8'h10, addr1=8'h20 -> gnt sequence
//      01,10,01,10; rom_addr 10,20,10,20; rsp_valid 01,10,01,10, starting 2 cycles later.
//   4. Fairness after idle: grant to 0, one idle cycle, then req=11 -> requester 1 wins
//      first (ptr=1).
//   5. Reset mid-flight: transfer at t, rst=0 at t+1 -> no rsp_valid at t+2.
//      After release, a new request completes normally.
//   6. ARB_LOCK_EN: req=11, lock=01 held -> requester 0 granted 8 consecutive cycles,
//      then requester 1 granted for 1 cycle, then requester 0 is granted again.

Source files
------------

// File: rtl/sine_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sine ROM port, with tagged 2-cycle responses.
// Optional feature: define ARB_LOCK_EN to add a per-requester lock input (bounded re-grant).
module sine_rom_arbiter #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8,
    parameter int N_REQ   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*A_WIDTH-1:0]   addr,
`ifdef ARB_LOCK_EN
    input  logic [N_REQ-1:0]           lock,
`endif
    output logic [N_REQ-1:0]           gnt,
    output logic [A_WIDTH-1:0]         rom_addr,
    input  logic [D_WIDTH-1:0]         rom_dout,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [D_WIDTH-1:0]         rsp_data
);

    localparam int IW = (N_REQ > 2) ? 2 : 1;

    logic [IW-1:0]      ptr;
    logic [IW-1:0]      win;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      next_ptr;
    logic [IW-1:0]      tag_id;
    logic               tag_v;
    logic               found;
    logic               locked;
    logic               transfer;
    logic [A_WIDTH-1:0] sel_addr;
    logic [A_WIDTH-1:0] last_addr;

`ifdef ARB_LOCK_EN
    logic [IW-1:0]      last_w;
    logic               last_v;
    logic [3:0]         lock_cnt;
    logic               lock_hit;

    assign lock_hit = last_v && req[last_w] && lock[last_w] && (lock_cnt < 4'd8);
`endif

    // A held lock re-grants the previous winner; otherwise scan upward from ptr.
    always_comb begin
        found  = 1'b0;
        win    = '0;
        idx    = '0;
        locked = 1'b0;
`ifdef ARB_LOCK_EN
        if (lock_hit) begin
            found  = 1'b1;
            win    = last_w;
            locked = 1'b1;
        end
`endif
        for (int k = 0; k < N_REQ; k++) begin
            idx = IW'((int'(ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign transfer = rst & found;
    assign next_ptr = (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);

    always_comb begin
        sel_addr = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win == IW'(k)) sel_addr = addr[k*A_WIDTH +: A_WIDTH];
        end
    end

    always_comb begin
        gnt = '0;
        if (transfer) gnt[win] = 1'b1;
    end

    assign rom_addr = transfer ? sel_addr : last_addr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr       <= '0;
            last_addr <= '0;
            tag_v     <= 1'b0;
            tag_id    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            tag_v <= transfer;
            if (transfer) begin
                tag_id    <= win;
                last_addr <= sel_addr;
                if (!locked) ptr <= next_ptr;
            end
            rsp_valid <= '0;
            if (tag_v) begin
                rsp_valid[tag_id] <= 1'b1;
                rsp_data          <= rom_dout;
            end
        end
    end

`ifdef ARB_LOCK_EN
    // The first grant of a locked streak counts as 1, so a streak tops out at 8 grants.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_w   <= '0;
            last_v   <= 1'b0;
            lock_cnt <= '0;
        end else begin
            if (transfer) begin
                last_w <= win;
                last_v <= 1'b1;
            end
            if (transfer && lock[win])
                lock_cnt <= locked ? lock_cnt + 4'd1 : 4'd1;
            else
                lock_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_sine_rom_arbiter.sv
// Self-checking bench for sine_rom_arbiter: directed scenarios followed by constrained-random
// traffic, all compared against a transaction-level reference model.
module tb_sine_rom_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int N  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   addr;
    logic [N-1:0]      gnt;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_dout;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_data;
`ifdef ARB_LOCK_EN
    logic [N-1:0]      lock = '0;
`endif

    logic [DW-1:0]     rom_mem [0:255];

    typedef struct {
        int            id;
        logic [AW-1:0] a;
        int            due;
    } pend_t;

    pend_t             pq[$];
    int                m_ptr;
    int                m_prev_win;
    int                edge_n;
    logic [AW-1:0]     m_last_addr;
    logic [N-1:0]      m_rsp_valid;
    logic [DW-1:0]     m_rsp_data;
`ifdef ARB_LOCK_EN
    bit                m_has_last;
    int                m_last_w;
    int                m_streak;
`endif

    int                checks = 0;
    int                errors = 0;

    logic [N-1:0]      cur_req;
    logic [N*AW-1:0]   cur_addr;
    logic              rs;

    sine_rom_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW), .N_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .addr      (addr),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_dout <= rom_mem[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner by the arbitration rules: held lock first, else first requester at or after ptr.
    task automatic modelWinner(output int win, output bit locked);
        win    = -1;
        locked = 1'b0;
        if (rst !== 1'b1) return;
`ifdef ARB_LOCK_EN
        if (m_has_last && req[m_last_w] && lock[m_last_w] && m_streak < 8) begin
            win    = m_last_w;
            locked = 1'b1;
            return;
        end
`endif
        for (int k = 0; k < N; k++) begin
            if (req[(m_ptr + k) % N]) begin
                win = (m_ptr + k) % N;
                return;
            end
        end
    endtask

    task automatic checkOutput();
        int            win;
        bit            locked;
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        modelWinner(win, locked);
        eg = (win >= 0) ? N'(1) << win : '0;
        ea = (win >= 0) ? addr[win*AW +: AW] : m_last_addr;
        check("gnt",       32'(gnt),       32'(eg));
        check("rom_addr",  32'(rom_addr),  32'(ea));
        check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
        check("rsp_data",  32'(rsp_data),  32'(m_rsp_data));
    endtask

    // Advance one clock edge and update the model with what was sampled at it.
    task automatic stepClock();
        int    win;
        bit    locked;
        pend_t p;
        modelWinner(win, locked);
        @(posedge clk);
        edge_n++;
        if (rst !== 1'b1) begin
            m_ptr       = 0;
            pq.delete();
            m_rsp_valid = '0;
            m_rsp_data  = '0;
            m_last_addr = '0;
            m_prev_win  = -1;
`ifdef ARB_LOCK_EN
            m_has_last  = 1'b0;
            m_last_w    = 0;
            m_streak    = 0;
`endif
        end else begin
            m_rsp_valid = '0;
            if (pq.size() > 0 && pq[0].due == edge_n) begin
                p           = pq.pop_front();
                m_rsp_valid = N'(1) << p.id;
                m_rsp_data  = rom_mem[p.a];
            end
            if (win >= 0) begin
                p.id  = win;
                p.a   = addr[win*AW +: AW];
                p.due = edge_n + 1;
                pq.push_back(p);
                m_last_addr = p.a;
                if (!locked) m_ptr = (win + 1) % N;
            end
`ifdef ARB_LOCK_EN
            if (win >= 0 && lock[win]) m_streak = locked ? m_streak + 1 : 1;
            else                       m_streak = 0;
            if (win >= 0) begin
                m_has_last = 1'b1;
                m_last_w   = win;
            end
`endif
            m_prev_win = win;
        end
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N*AW-1:0] a, input logic rs_in);
        rst  = rs_in;
        req  = r;
        addr = a;
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = DW'($urandom);
        rom_mem[8'h40] = 8'hFF;
        edge_n = 0;

        // Reset held for three edges with every requester asking.
        rst  = 1'b0;
        req  = '1;
        addr = '0;
        stepClock();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(2'b11, 16'h0000, 1'b0);
            check("reset_gnt",      32'(gnt),       32'd0);
            check("reset_rom_addr", 32'(rom_addr),  32'd0);
            check("reset_rsp",      32'(rsp_valid), 32'd0);
            stepClock();
        end

        // Single read of address 0x40, which holds 0xFF.
        applyStimulus(2'b01, 16'h0040, 1'b1);
        check("single_gnt",  32'(gnt),      32'h1);
        check("single_addr", 32'(rom_addr), 32'h40);
        stepClock();
        applyStimulus(2'b00, 16'h0040, 1'b1);
        stepClock();
        applyStimulus(2'b00, 16'h0040, 1'b1);
        check("single_rsp_valid", 32'(rsp_valid), 32'h1);
        check("single_rsp_data",  32'(rsp_data),  32'hFF);
        stepClock();
        applyStimulus(2'b00, 16'h0040, 1'b1);
        check("single_rsp_drop", 32'(rsp_valid), 32'h0);
        check("single_rsp_hold", 32'(rsp_data),  32'hFF);
        stepClock();

        // Fairness after idle: grant 0, idle, then both ask and 1 goes first.
        applyStimulus(2'b01, 16'h2010, 1'b1);
        check("fair_first", 32'(gnt), 32'h1);
        stepClock();
        applyStimulus(2'b00, 16'h2010, 1'b1);
        check("idle_addr_hold", 32'(rom_addr), 32'h10);
        stepClock();
        applyStimulus(2'b11, 16'h2010, 1'b1);
        check("fair_after_idle", 32'(gnt), 32'h2);
        stepClock();

        // Contention: strict alternation of grants and of responses two cycles later.
        for (int k = 0; k < 6; k++) begin
            applyStimulus((k < 4) ? 2'b11 : 2'b00, 16'h2010, 1'b1);
            if (k < 4) begin
                check("cont_gnt",  32'(gnt),      (k % 2) ? 32'h2 : 32'h1);
                check("cont_addr", 32'(rom_addr), (k % 2) ? 32'h20 : 32'h10);
            end
            if (k >= 2) check("cont_rsp", 32'(rsp_valid), ((k - 2) % 2) ? 32'h2 : 32'h1);
            stepClock();
        end

        // Reset while a read is in flight drops its response.
        applyStimulus(2'b01, 16'h0055, 1'b1);
        stepClock();
        applyStimulus(2'b00, 16'h0055, 1'b0);
        stepClock();
        applyStimulus(2'b00, 16'h0055, 1'b1);
        check("midreset_no_rsp", 32'(rsp_valid), 32'h0);
        stepClock();
        applyStimulus(2'b10, 16'h7700, 1'b1);
        check("post_reset_gnt", 32'(gnt), 32'h2);
        stepClock();
        applyStimulus(2'b00, 16'h7700, 1'b1);
        stepClock();
        applyStimulus(2'b00, 16'h7700, 1'b1);
        check("post_reset_rsp",  32'(rsp_valid), 32'h2);
        check("post_reset_data", 32'(rsp_data),  32'(rom_mem[8'h77]));
        stepClock();

`ifdef ARB_LOCK_EN
        // Locked requester 0 gets 8 grants, then 1 gets one, then 0 again.
        applyStimulus(2'b00, 16'h0000, 1'b0);
        stepClock();
        lock = 2'b01;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(2'b11, 16'h3130, 1'b1);
            check("lock_gnt", 32'(gnt), (k == 8) ? 32'h2 : 32'h1);
            stepClock();
        end
        lock = '0;
`endif

        // Random traffic obeying the hold-until-granted handshake, with occasional resets.
        cur_req  = '0;
        cur_addr = '0;
        for (int c = 0; c < 300; c++) begin
            rs = ($urandom_range(0, 39) != 0);
`ifdef ARB_LOCK_EN
            lock = N'($urandom);
`endif
            applyStimulus(cur_req, cur_addr, rs);
            stepClock();
            for (int i = 0; i < N; i++) begin
                if (!(cur_req[i] && m_prev_win != i && $urandom_range(0, 7) != 0)) begin
                    cur_req[i]            = 1'($urandom_range(0, 1));
                    cur_addr[i*AW +: AW]  = AW'($urandom);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
